// File: rtl/uart_frame_transmit.sv
// Framed serial transmitter: start, 4-bit size, 1-16 payload bytes, CRC-8, stop.
// Optional PARITY_EN macro inserts an even-parity bit after each data byte.
module uart_frame_transmit #(
  parameter int         MAXBYTES = 16,
  parameter logic [7:0] CRCPOLY  = 8'h07
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] baudrate,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] crcout
);

  localparam logic [4:0] MAXB = 5'(MAXBYTES);

  typedef enum logic [2:0] {IDLE, LOAD, START, SIZE, DATA, CRC, STOP} state_t;

  state_t     state, state_nxt;
  logic [4:0] count, count_nxt;
  logic [7:0] bitcnt, bitcnt_nxt;
  logic [7:0] baud_q, baud_nxt;
  logic [2:0] bitidx, bitidx_nxt;
  logic [3:0] byteidx, byteidx_nxt;
  logic       par_phase, par_nxt;
  logic       tx_q, tx_nxt;
  logic       done_q, done_nxt;
  logic [7:0] crcout_q, crcout_nxt;

  logic [7:0] crc_acc;
  logic [7:0] crc_new;
  logic [7:0] mem [MAXBYTES];

  logic       accept;
  logic       close;
  logic       byte_end;
  logic       last_byte;
  logic [4:0] size_w;
  logic [7:0] cur;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ CRCPOLY) : (c << 1);
    return c;
  endfunction

  assign din_ready = ((state == IDLE) || (state == LOAD)) && (count < MAXB);
  assign accept    = din_valid && din_ready;
  assign close     = din_last || (count == MAXB - 5'd1);
  // The first byte of a frame restarts the CRC from zero.
  assign crc_new   = crc8_byte((state == IDLE) ? 8'h00 : crc_acc, din);
  assign size_w    = count - 5'd1;
  assign cur       = mem[byteidx];
  assign last_byte = ({1'b0, byteidx} == size_w);
`ifdef PARITY_EN
  assign byte_end  = par_phase;
`else
  assign byte_end  = (bitidx == 3'd7);
`endif

  assign tx     = tx_q;
  assign busy   = (state != IDLE);
  assign done   = done_q;
  assign crcout = crcout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= 5'd0;
      bitcnt    <= 8'd0;
      baud_q    <= 8'd0;
      bitidx    <= 3'd0;
      byteidx   <= 4'd0;
      par_phase <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      crcout_q  <= 8'h00;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      bitcnt    <= bitcnt_nxt;
      baud_q    <= baud_nxt;
      bitidx    <= bitidx_nxt;
      byteidx   <= byteidx_nxt;
      par_phase <= par_nxt;
      tx_q      <= tx_nxt;
      done_q    <= done_nxt;
      crcout_q  <= crcout_nxt;
    end
  end

  // Payload buffer and running CRC are pure data; they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[count[3:0]] <= din;
      crc_acc         <= crc_new;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    bitcnt_nxt  = bitcnt;
    baud_nxt    = baud_q;
    bitidx_nxt  = bitidx;
    byteidx_nxt = byteidx;
    par_nxt     = par_phase;
    tx_nxt      = tx_q;
    done_nxt    = 1'b0;
    crcout_nxt  = crcout_q;

    if ((state == IDLE) || (state == LOAD)) begin
      if (accept) begin
        count_nxt = count + 5'd1;
        state_nxt = LOAD;
        if (close) begin
          state_nxt  = START;
          baud_nxt   = baudrate;
          bitcnt_nxt = baudrate - 8'd1;
          crcout_nxt = crc_new;
          tx_nxt     = 1'b0;
        end
      end
    end else if (bitcnt != 8'd0) begin
      bitcnt_nxt = bitcnt - 8'd1;
    end else begin
      bitcnt_nxt = baud_q - 8'd1;
      case (state)
        START: begin
          state_nxt  = SIZE;
          bitidx_nxt = 3'd0;
          tx_nxt     = size_w[0];
        end
        SIZE: begin
          if (bitidx == 3'd3) begin
            state_nxt   = DATA;
            bitidx_nxt  = 3'd0;
            byteidx_nxt = 4'd0;
            par_nxt     = 1'b0;
            tx_nxt      = mem[0][0];
          end else begin
            bitidx_nxt = bitidx + 3'd1;
            tx_nxt     = size_w[bitidx_nxt[1:0]];
          end
        end
        DATA: begin
          if (byte_end) begin
            bitidx_nxt = 3'd0;
            par_nxt    = 1'b0;
            if (last_byte) begin
              state_nxt = CRC;
              tx_nxt    = crcout_q[0];
            end else begin
              byteidx_nxt = byteidx + 4'd1;
              tx_nxt      = mem[byteidx_nxt][0];
            end
          end
`ifdef PARITY_EN
          else if (bitidx == 3'd7) begin
            par_nxt = 1'b1;
            tx_nxt  = ^cur;
          end
`endif
          else begin
            bitidx_nxt = bitidx + 3'd1;
            tx_nxt     = cur[bitidx_nxt];
          end
        end
        CRC: begin
          if (bitidx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bitidx_nxt = bitidx + 3'd1;
            tx_nxt     = crcout_q[bitidx_nxt];
          end
        end
        STOP: begin
          state_nxt = IDLE;
          count_nxt = 5'd0;
          done_nxt  = 1'b1;
          tx_nxt    = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_transmit.sv
// Directed bench for uart_frame_transmit; builds expected tx streams from the payload.
module tb_uart_frame_transmit;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] baudrate = 8'd4;
  logic [7:0] din = 8'd0;
  logic       din_valid = 1'b0;
  logic       din_last = 1'b0;
  logic       din_ready, tx, busy, done;
  logic [7:0] crcout;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] pay [16];
  int npay = 0;

  uart_frame_transmit dut (
    .clk(clk), .reset_n(reset_n), .baudrate(baudrate), .din(din),
    .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .tx(tx), .busy(busy), .done(done), .crcout(crcout)
  );

  always #5 clk = ~clk;

`ifdef PARITY_EN
  localparam int PER = 9;
`else
  localparam int PER = 8;
`endif

  // Bit-serial CRC-8 (poly 0x07) over the payload, MSB first.
  function automatic logic [7:0] crc_model();
    logic [7:0] c = 8'h00;
    logic fb;
    for (int i = 0; i < npay; i++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ pay[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return c;
  endfunction

  function automatic int frame_len();
    return 1 + 4 + PER * npay + 8 + 1;
  endfunction

  function automatic logic exp_bit(input int k);
    logic [3:0] sz;
    logic [7:0] by;
    logic [7:0] cr;
    sz = 4'(npay - 1);
    cr = crc_model();
    if (k == 0) return 1'b0;
    k = k - 1;
    if (k < 4) return sz[k];
    k = k - 4;
    if (k < PER * npay) begin
      by = pay[k / PER];
      if ((k % PER) == 8) return ^by;
      return by[k % PER];
    end
    k = k - PER * npay;
    if (k < 8) return cr[k];
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input bit close);
    for (int i = 0; i < n; i++) begin
      din       = pay[i];
      din_valid = 1'b1;
      din_last  = close && (i == n - 1);
      tick();
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  // Entered in the first START cycle; leaves in the done cycle.
  task automatic check_frame(input string name, input int nb, input int newbaud);
    int len, bad, first_c;
    logic first_act, first_exp;
    len = frame_len();
    bad = 0;
    first_c = -1;
    first_act = 1'b0;
    first_exp = 1'b0;
    for (int c = 0; c < len * nb; c++) begin
      if (c == 100 && newbaud >= 0) baudrate = 8'(newbaud);
      if (tx !== exp_bit(c / nb) || busy !== 1'b1 || din_ready !== 1'b0 || done !== 1'b0) begin
        if (bad == 0) begin
          first_c = c; first_act = tx; first_exp = exp_bit(c / nb);
        end
        bad++;
      end
      tick();
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_bits: %0d bad cycles, first at cycle %0d tx=%b expected %b (busy=%b ready=%b done=%b)",
               name, bad, first_c, first_act, first_exp, busy, din_ready, done);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b tx=%b expected done=1 busy=0 tx=1", name, done, busy, tx);
    end
    vectors++;
    if (crcout !== crc_model()) begin
      errors++;
      $display("FAIL %s_crc: crcout=%h expected %h", name, crcout, crc_model());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || crcout !== 8'h00 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b crcout=%h ready=%b expected 1 0 0 00 1",
               tx, busy, done, crcout, din_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    baudrate = 8'd4;
    pay[0] = 8'hA5; npay = 1;
    feed(1, 1'b1);
    check_frame("single", 4, -1);
    vectors++;
    if (crcout !== 8'h72) begin
      errors++;
      $display("FAIL single_crc_const: crcout=%h expected 72", crcout);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_after: done=%b ready=%b expected 0 1", done, din_ready);
    end
  endtask

  task automatic test_autoclose();
    baudrate = 8'd2;
    for (int i = 0; i < 16; i++) pay[i] = 8'(i);
    npay = 16;
    feed(16, 1'b0);
    vectors++;
    if (din_ready !== 1'b0 || tx !== 1'b0) begin
      errors++;
      $display("FAIL autoclose_start: ready=%b tx=%b expected 0 0", din_ready, tx);
    end
    check_frame("autoclose", 2, -1);
    tick();
  endtask

  task automatic test_baud0();
    baudrate = 8'd0;
    pay[0] = 8'h5A; npay = 1;
    feed(1, 1'b1);
    check_frame("baud0", 256, 3);
    baudrate = 8'd4;
    tick();
  endtask

  task automatic test_back_to_back();
    baudrate  = 8'd3;
    din       = 8'hFF;
    din_valid = 1'b1;
    din_last  = 1'b0;
    tick();
    din_last  = 1'b1;
    tick();
    pay[0] = 8'hFF; pay[1] = 8'hFF; npay = 2;
    check_frame("b2b_first", 3, -1);
    vectors++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_done: ready=%b expected 1", din_ready);
    end
    tick();
    din_valid = 1'b0;
    din_last  = 1'b0;
    npay = 1;
    check_frame("b2b_second", 3, -1);
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    baudrate = 8'd4;
    pay[0] = 8'hC3; npay = 1;
    feed(1, 1'b1);
    repeat (26) tick();
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || crcout !== 8'h00) begin
      errors++;
      $display("FAIL midreset_async: tx=%b busy=%b done=%b crcout=%h expected 1 0 0 00",
               tx, busy, done, crcout);
    end
    repeat (3) tick();
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b0 || tx !== 1'b1 || din_ready !== 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_idle: %0d cycles with done/tx/ready off idle values (done=%b tx=%b ready=%b)",
               seen, done, tx, din_ready);
    end
    pay[0] = 8'h3C; npay = 1;
    feed(1, 1'b1);
    check_frame("midreset_next", 4, -1);
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_autoclose();
    test_baud0();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
